maxpool_ch_sched: RTL
=====================

Name: maxpool_ch_sched

Overview:
Channel scheduler for one shared max-pool engine.
- Takes a multi-channel feature map and runs each active channel through the engine, one channel at a time.
- Drives the engine's work_en/data_i and waits for its work_fin.
- Collects each pooled result into a multi-channel output buffer.
- Sits between the layer controller (start/done) and the single pooling engine instance.

Parameters:
CHANNELS, 4, maximum channels per job
DI_W, 4, input map width
DI_H, 4, input map height
DO_W, 2, pooled map width (must match engine)
DO_H, 2, pooled map height (must match engine)
BITWIDTH, 3, bits per element
TIMEOUT, 255, max cycles from work_en pulse to work_fin before error
CFG_W, clog2(CHANNELS+1), width of cfg_ch_num

Ports:
clk_en  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  job request, sampled only in IDLE
cfg_ch_num  in  CFG_W  active channel count, latched on accepted start
fmap_i  in  CHANNELS*DI_W*DI_H*BITWIDTH  input maps; channel k occupies slice k
pool_work_en  out  1  one-cycle start pulse to engine
pool_data_o  out  DI_W*DI_H*BITWIDTH  registered channel slice fed to engine
pool_data_i  in  DO_W*DO_H*BITWIDTH  engine result
pool_work_fin  in  1  engine finish flag (level; cleared by engine one cycle after work_en)
fmap_o  out  CHANNELS*DO_W*DO_H*BITWIDTH  pooled maps; channel k in slice k
ch_idx  out  clog2(CHANNELS)  channel currently in flight
busy  out  1  job in progress
done  out  1  sticky: job completed, cleared on next accepted start
err_timeout  out  1  sticky watchdog error

Behaviour:
Reset values:
- All outputs 0.
- State IDLE, watchdog 0.

State IDLE:
- busy=0.
- On start=1 the scheduler:
  - latches n = min(cfg_ch_num, CHANNELS);
  - clears fmap_o and done;
  - sets ch_idx=0.
- If n==0 -> DONE; else -> LOAD.

State LOAD (1 cycle):
- pool_data_o <= fmap_i slice ch_idx.
- -> FIRE.

State FIRE (1 cycle):
- pool_work_en=1.
- Watchdog cleared.
- -> WAIT_CLR.

State WAIT_CLR:
- Wait for pool_work_fin==0; this masks the stale fin level left by the previous channel.
- -> WAIT_FIN.

State WAIT_FIN:
- On pool_work_fin==1 -> STORE.

State STORE (1 cycle):
- fmap_o slice ch_idx <= pool_data_i.
- If ch_idx==n-1 -> DONE; else ch_idx++ and -> LOAD.

State DONE (1 cycle):
- done<=1 and -> IDLE.
- busy=1 in LOAD..STORE and DONE.

State ERR (terminal):
- Entered when the watchdog reaches TIMEOUT while in WAIT_CLR or WAIT_FIN.
- err_timeout=1, busy=0, start ignored.
- Exit only via reset.

Timing and rules:
- Watchdog counts every cycle in WAIT_CLR/WAIT_FIN and saturates at TIMEOUT.
- Per-channel cycles = 4 + cycles spent in WAIT_FIN.
- start while busy is ignored; cfg_ch_num and fmap_i changes mid-job have no effect on n.
- fmap_i is sampled per channel at LOAD, so the caller must hold fmap_i stable while busy.
- pool_data_o holds its value after the job ends.
- fmap_o slices beyond n stay 0.
- Reset mid-job aborts immediately: all outputs return to 0 and ERR is exited.
- pool_work_en is never asserted outside FIRE, and never two cycles in a row.

Decomposition:
- Shared package maxpool_sched_pkg holds:
  - the state encoding (IDLE, LOAD, FIRE, WAIT_CLR, WAIT_FIN, STORE, DONE, ERR);
  - slice width constants: IN_SLICE = DI_W*DI_H*BITWIDTH, OUT_SLICE = DO_W*DO_H*BITWIDTH.
- One sub-module, maxpool_sched_wdog: clear/enable/saturating counter with an expired flag, parameterised by TIMEOUT.

Test Plan:
1. Reset, then start with cfg_ch_num=4 and a behavioural engine returning channel k's sum mod 8 after 5 cycles -> exactly 4 single-cycle pool_work_en pulses; fmap_o slice k holds the engine results; done=1; each channel takes 4+5 = 9 cycles.
2. Job with cfg_ch_num=2, then a second job with cfg_ch_num=7 -> job 1 leaves fmap_o slices 2..3 at 0; job 2 clamps n to 4; done clears on the second start and re-asserts at its end.
3. start with cfg_ch_num=0 -> no pool_work_en; busy high for 1 cycle; done=1 on the next cycle.
4. Engine holds pool_work_fin=1 from the prior job and drops it one cycle after work_en -> the scheduler does not store early; STORE occurs only on the new fin rising edge.
5. Engine never raises fin, TIMEOUT=255 -> err_timeout=1 after 255 wait cycles; busy=0; a later start is ignored; reset clears err_timeout.
6. reset_n low during WAIT_FIN of channel 2 -> the next cycle has all outputs 0 and state IDLE; a fresh start runs a full job correctly.

Source files
------------

// File: rtl/maxpool_sched_pkg.sv
// Shared definitions for the max-pool channel scheduler: FSM state encoding,
// default geometry and the per-channel slice widths derived from it.
package maxpool_sched_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DI_W     = 4;
    localparam int DEF_DI_H     = 4;
    localparam int DEF_DO_W     = 2;
    localparam int DEF_DO_H     = 2;
    localparam int DEF_BITWIDTH = 3;

    localparam int IN_SLICE  = DEF_DI_W * DEF_DI_H * DEF_BITWIDTH;
    localparam int OUT_SLICE = DEF_DO_W * DEF_DO_H * DEF_BITWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT_CLR,
        ST_WAIT_FIN,
        ST_STORE,
        ST_DONE,
        ST_ERR
    } sched_state_t;

endpackage

// File: rtl/maxpool_ch_sched_if.sv
// Handshake and data bus between the channel scheduler (master) and the
// shared pooling engine (slave).
interface maxpool_ch_sched_if
    import maxpool_sched_pkg::*;
#(
    parameter int IN_W  = IN_SLICE,
    parameter int OUT_W = OUT_SLICE
);
    logic             pool_work_en;
    logic [IN_W-1:0]  pool_data_o;
    logic [OUT_W-1:0] pool_data_i;
    logic             pool_work_fin;

    modport master (
        output pool_work_en,
        output pool_data_o,
        input  pool_data_i,
        input  pool_work_fin
    );

    modport slave (
        input  pool_work_en,
        input  pool_data_o,
        output pool_data_i,
        output pool_work_fin
    );
endinterface

// File: rtl/maxpool_sched_wdog.sv
// Saturating watchdog counter; expired_o flags the cycle in which the count
// reaches TIMEOUT (and stays high while it is held there).
module maxpool_sched_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_en,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && (count_q != LIM))
            count_d = count_q + CW'(1);
    end

    assign expired_o = en_i && !clr_i && (count_d == LIM);

    always_ff @(posedge clk_en) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/maxpool_ch_sched.sv
// Runs each active channel of a feature map through one shared max-pool
// engine and gathers the pooled slices into a multi-channel output buffer.
module maxpool_ch_sched
    import maxpool_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DI_W     = DEF_DI_W,
    parameter int DI_H     = DEF_DI_H,
    parameter int DO_W     = DEF_DO_W,
    parameter int DO_H     = DEF_DO_H,
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int TIMEOUT  = 255,
    parameter int CFG_W    = $clog2(CHANNELS + 1),
    localparam int IN_W    = DI_W * DI_H * BITWIDTH,
    localparam int OUT_W   = DO_W * DO_H * BITWIDTH,
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_en,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CFG_W-1:0]          cfg_ch_num,
    input  logic [CHANNELS*IN_W-1:0]  fmap_i,
    maxpool_ch_sched_if.master        eng,
    output logic [CHANNELS*OUT_W-1:0] fmap_o,
    output logic [IDX_W-1:0]          ch_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);
    sched_state_t              state_q;
    logic [CFG_W-1:0]          n_q;
    logic [IDX_W-1:0]          ch_idx_q;
    logic [IN_W-1:0]           data_q;
    logic [CHANNELS*OUT_W-1:0] fmap_q;
    logic                      work_en_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;

    logic [CFG_W-1:0] n_clamp;
    logic             in_wait;
    logic             wd_expired;
    logic             last_ch;

    assign n_clamp = (cfg_ch_num > CFG_W'(CHANNELS)) ? CFG_W'(CHANNELS) : cfg_ch_num;
    assign in_wait = (state_q == ST_WAIT_CLR) || (state_q == ST_WAIT_FIN);
    assign last_ch = (CFG_W'(ch_idx_q) == (n_q - CFG_W'(1)));

    maxpool_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_en    (clk_en),
        .reset_n   (reset_n),
        .clr_i     (state_q == ST_FIRE),
        .en_i      (in_wait),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_en) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            ch_idx_q  <= '0;
            data_q    <= '0;
            fmap_q    <= '0;
            work_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            work_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q      <= n_clamp;
                        fmap_q   <= '0;
                        done_q   <= 1'b0;
                        ch_idx_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (n_clamp == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    data_q    <= fmap_i[ch_idx_q*IN_W +: IN_W];
                    work_en_q <= 1'b1;
                    state_q   <= ST_FIRE;
                end
                ST_FIRE: begin
                    state_q <= ST_WAIT_CLR;
                end
                // A fin level left over from the previous channel must drop
                // before a rising fin can be trusted as this channel's result.
                ST_WAIT_CLR: begin
                    if (!eng.pool_work_fin) begin
                        state_q <= ST_WAIT_FIN;
                    end else if (wd_expired) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_ERR;
                    end
                end
                ST_WAIT_FIN: begin
                    if (eng.pool_work_fin) begin
                        state_q <= ST_STORE;
                    end else if (wd_expired) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_ERR;
                    end
                end
                ST_STORE: begin
                    fmap_q[ch_idx_q*OUT_W +: OUT_W] <= eng.pool_data_i;
                    if (last_ch) begin
                        state_q <= ST_DONE;
                    end else begin
                        ch_idx_q <= ch_idx_q + IDX_W'(1);
                        state_q  <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng.pool_work_en = work_en_q;
    assign eng.pool_data_o  = data_q;
    assign fmap_o           = fmap_q;
    assign ch_idx           = ch_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_timeout      = err_q;
endmodule
